// File: rtl/vga_fetch_sched_if.sv
// Wishbone read-master bundle between the VGA fetch scheduler and the memory port.
interface vga_fetch_sched_if #(
  parameter int AW = 30
);
  logic          mem_cyc;
  logic [AW-1:0] mem_adr;
  logic [2:0]    mem_cti;
  logic          mem_ack;
  logic          mem_err;

  modport master (output mem_cyc, mem_adr, mem_cti, input mem_ack, mem_err);
  modport slave  (input mem_cyc, mem_adr, mem_cti, output mem_ack, mem_err);
endinterface

// File: rtl/vga_fetch_sched.sv
// Shares the VGA Wishbone read master between video-data bursts and CLUT lookups.
// Define VGA_FETCH_TIMEOUT_EN to abort a beat after 255 cycles without ack/err.
module vga_fetch_sched #(
  parameter int AW        = 30,
  parameter int LVL_W     = 5,
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 8,
  parameter int LOW_MARK  = 4
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 ven,
  input  logic                 frame_start,
  input  logic [AW-1:0]        vbase,
  input  logic [23:0]          frame_words,
  input  logic [LVL_W-1:0]     vdat_level,
  input  logic                 clut_req,
  input  logic [7:0]           clut_idx,
  input  logic [AW-9:0]        clut_base,
  vga_fetch_sched_if.master    mem,
  output logic                 vdat_wreq,
  output logic                 clut_ack,
  output logic                 err_int
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [LVL_W-1:0] URGENT_LVL = LVL_W'(LOW_MARK);
  localparam logic [LVL_W-1:0] ROOM_LVL   = LVL_W'(DEPTH - BURST_LEN);

  typedef enum logic [1:0] {IDLE, VBURST, CREAD} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] fetch_adr_reg, fetch_adr_next;
  logic [23:0]   remain_reg, remain_next;
  logic          reload_pend_reg, reload_pend_next;
  logic [BW-1:0] beat_reg, beat_next;
  logic [AW-1:0] clut_adr_reg, clut_adr_next;

  logic          busy;
  logic          timeout;
  logic          err_eff;
  logic          ack_eff;
  logic [BW-1:0] blen;

  assign busy    = (state_reg != IDLE);
  assign err_eff = busy & (mem.mem_err | timeout);
  assign ack_eff = busy & mem.mem_ack & ~err_eff;
  // Burst never runs past the end of the frame.
  assign blen    = (remain_reg < 24'(BURST_LEN)) ? BW'(remain_reg) : BW'(BURST_LEN);

`ifdef VGA_FETCH_TIMEOUT_EN
  logic [7:0] to_cnt_reg, to_cnt_next;

  assign timeout = busy & ~mem.mem_ack & ~mem.mem_err & (to_cnt_reg == 8'd254);

  always_comb begin
    to_cnt_next = to_cnt_reg + 8'd1;
    if (!busy || mem.mem_ack || mem.mem_err || timeout) begin
      to_cnt_next = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      to_cnt_reg <= 8'd0;
    end else begin
      to_cnt_reg <= to_cnt_next;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg       <= IDLE;
      fetch_adr_reg   <= '0;
      remain_reg      <= '0;
      reload_pend_reg <= 1'b0;
      beat_reg        <= '0;
      clut_adr_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      fetch_adr_reg   <= fetch_adr_next;
      remain_reg      <= remain_next;
      reload_pend_reg <= reload_pend_next;
      beat_reg        <= beat_next;
      clut_adr_reg    <= clut_adr_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    fetch_adr_next   = fetch_adr_reg;
    remain_next      = remain_reg;
    reload_pend_next = reload_pend_reg;
    beat_next        = beat_reg;
    clut_adr_next    = clut_adr_reg;
    vdat_wreq        = 1'b0;
    clut_ack         = 1'b0;
    err_int          = 1'b0;

    case (state_reg)
      IDLE: begin
        // A reload cycle launches nothing, so the new frame starts cleanly.
        if (reload_pend_reg || remain_reg == 24'd0) begin
          fetch_adr_next   = vbase;
          remain_next      = frame_words;
          reload_pend_next = 1'b0;
        end else if (ven && vdat_level < URGENT_LVL) begin
          state_next = VBURST;
          beat_next  = blen;
        end else if (clut_req) begin
          state_next    = CREAD;
          clut_adr_next = {clut_base, clut_idx};
        end else if (ven && vdat_level <= ROOM_LVL) begin
          state_next = VBURST;
          beat_next  = blen;
        end
      end

      VBURST: begin
        vdat_wreq = ack_eff;
        err_int   = err_eff;
        if (ack_eff || err_eff) begin
          fetch_adr_next = fetch_adr_reg + AW'(1);
          remain_next    = remain_reg - 24'd1;
          beat_next      = beat_reg - BW'(1);
          if (err_eff || beat_reg == BW'(1)) begin
            state_next = IDLE;
          end
        end
      end

      CREAD: begin
        clut_ack = ack_eff;
        err_int  = err_eff;
        if (ack_eff || err_eff) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    if (frame_start) begin
      reload_pend_next = 1'b1;
    end
  end

  always_comb begin
    mem.mem_cyc = busy;
    mem.mem_adr = '0;
    mem.mem_cti = 3'b000;
    if (state_reg == VBURST) begin
      mem.mem_adr = fetch_adr_reg;
      mem.mem_cti = (beat_reg == BW'(1)) ? 3'b111 : 3'b010;
    end else if (state_reg == CREAD) begin
      mem.mem_adr = clut_adr_reg;
    end
  end

endmodule
